// File: rtl/mem_responder.sv
// Register-file memory responder with a fixed number of wait states per access.
// Serves one read or write per request/ready handshake; memory resets to mem[i] = i.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WS_CNT  = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_check
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_en;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        acc_en    = 1'b0;
        acc_wr    = op_wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (ren ^ wen) begin
                    op_wr_d = wen;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WS_CNT;
                    // With no wait states the access uses the live inputs on the accepting edge.
                    if (NO_WAIT) begin
                        acc_en    = 1'b1;
                        acc_wr    = wen;
                        acc_addr  = addr;
                        acc_wdata = wdata;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (ren && wen) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!(op_wr_q ? wen : ren)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    acc_en  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (acc_en && !acc_wr) begin
            rdata_d = mem_q[acc_addr];
        end
        ready_d = acc_en;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (acc_en && acc_wr) begin
                mem_q[acc_addr] <= acc_wdata;
            end
        end
    end

    // Request payload latches carry no reset; they are only consumed after a fresh acceptance.
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder against an array-based memory model.
module tb_mem_responder;

    localparam int WS = 2;

    logic       CLK;
    logic       nRST;
    logic       ren;
    logic       wen;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready;
    logic       err;

    mem_responder #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .WAIT_STATES(WS)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ren  (ren),
        .wen  (wen),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .err  (err)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] rd;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] mem_m [256];
    logic [7:0] last_rd;
    int         n_chk;
    int         n_fail;
    bit         prev_ready;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
        last_rd = 8'h00;
        q.delete();
    endtask

    // Complete read or write; optionally scrambles addr/wdata after acceptance.
    task automatic txn(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit scramble);
        exp_t e;
        int   lat;
        @(posedge CLK); #1;
        ren   = !wr;
        wen   = wr;
        addr  = a;
        wdata = d;
        if (wr) mem_m[a] = d;
        else    last_rd = mem_m[a];
        e.is_err = 1'b0;
        e.rd     = last_rd;
        q.push_back(e);
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (scramble) begin
                addr  = 8'($urandom);
                wdata = 8'($urandom);
            end
        end while (!ready && lat < 20);
        chk("latency", lat, WS + 1);
        if (!ready && q.size() > 0) void'(q.pop_back());
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic err_txn(input logic [7:0] a);
        exp_t e;
        @(posedge CLK); #1;
        ren  = 1'b1;
        wen  = 1'b1;
        addr = a;
        e.is_err = 1'b1;
        e.rd     = last_rd;
        q.push_back(e);
        @(posedge CLK); #1;
        chk("err_pulse", err, 1);
        ren = 1'b0;
        wen = 1'b0;
        @(posedge CLK); #1;
        chk("err_width", err, 0);
    endtask

    // Request dropped after k accepting/wait edges, always before completion.
    task automatic abort_txn(input bit wr, input logic [7:0] a, input logic [7:0] d, input int k);
        @(posedge CLK); #1;
        ren   = !wr;
        wen   = wr;
        addr  = a;
        wdata = d;
        repeat (k) @(posedge CLK);
        #1;
        ren = 1'b0;
        wen = 1'b0;
        repeat (WS + 1) begin
            @(posedge CLK); #1;
            chk("abort_no_ready", ready, 0);
        end
    endtask

    always @(negedge CLK) begin
        if (!nRST) begin
            prev_ready = 1'b0;
        end else begin
            if (ready) chk("ready_width", prev_ready, 0);
            if (ready || err) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: ready=%b err=%b with nothing outstanding at %0t",
                             ready, err, $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_err", err, mon_e.is_err);
                    chk("out_ready", ready, !mon_e.is_err);
                    chk("out_rdata", rdata, mon_e.rd);
                end
            end
            prev_ready = ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] a;
        logic [7:0] d;
        n_chk = 0;
        n_fail = 0;
        ren = 1'b0;
        wen = 1'b0;
        addr = 8'h00;
        wdata = 8'h00;
        nRST = 1'b1;
        model_reset();
        #2 nRST = 1'b0;
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_err", err, 0);
        chk("reset_rdata", rdata, 0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Directed: reset pattern, write/readback, neighbour intact.
        txn(0, 8'h10, 8'h00, 0);
        txn(1, 8'h20, 8'hC3, 0);
        txn(0, 8'h20, 8'h00, 0);
        txn(0, 8'h21, 8'h00, 0);

        // Aborts leave memory untouched.
        abort_txn(0, 8'h30, 8'h00, 1);
        abort_txn(1, 8'h30, 8'hEE, WS);
        abort_txn(1, 8'h31, 8'hDD, 1);
        txn(0, 8'h30, 8'h00, 0);
        txn(0, 8'h31, 8'h00, 0);

        // Conflicting request gives err only.
        err_txn(8'h32);
        txn(0, 8'h32, 8'h00, 0);

        // Payload changes after acceptance are ignored.
        txn(1, 8'h33, 8'h5C, 1);
        txn(0, 8'h33, 8'h00, 1);

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            d = 8'($urandom);
            if (r < 40)      txn(0, a, d, 1'($urandom));
            else if (r < 80) txn(1, a, d, 1'($urandom));
            else if (r < 90) err_txn(a);
            else             abort_txn(r[0], a, d, int'($urandom_range(1, WS)));
        end

        // Reset in the middle of a write's wait period.
        txn(1, 8'hFE, 8'hA5, 0);
        txn(0, 8'hFE, 8'h00, 0);
        @(posedge CLK); #1;
        wen   = 1'b1;
        addr  = 8'h40;
        wdata = 8'h5A;
        @(posedge CLK); #2;
        nRST = 1'b0;
        #1;
        chk("midreset_ready", ready, 0);
        chk("midreset_err", err, 0);
        chk("midreset_rdata", rdata, 0);
        wen = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
        txn(0, 8'h40, 8'h00, 0);
        txn(0, 8'hFE, 8'h00, 0);

        // Random traffic after reset, then a full memory sweep.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) txn(1, 8'($urandom), 8'($urandom), 0);
            else                           txn(0, 8'($urandom), 8'h00, 0);
        end
        for (int i = 0; i < 256; i++) txn(0, 8'(i), 8'h00, 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
